// File: rtl/cpu_clock_controller.sv
// Clock-enable and reset sequencer for the 16-bit CPU: holds the core in reset,
// then runs it at a divided rate or single-steps it, counting every tick.
module cpu_clock_controller #(
   parameter int DIV_WIDTH   = 8,
   parameter int STEP_WIDTH  = 16,
   parameter int COUNT_WIDTH = 32,
   parameter int RESET_HOLD  = 4
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [1:0]             Mode,
   input  logic                   Start,
   input  logic                   Halt,
   input  logic [DIV_WIDTH-1:0]   Divide,
   input  logic [STEP_WIDTH-1:0]  StepCount,
   output logic                   CpuEnable,
   output logic                   CpuReset_n,
   output logic [COUNT_WIDTH-1:0] CycleCount,
   output logic                   Halted,
   output logic                   Done
);

   localparam int HW = $clog2(RESET_HOLD + 1);

   typedef enum logic [1:0] {
      S_HOLD = 2'b00,
      S_IDLE = 2'b01,
      S_RUN  = 2'b10,
      S_STEP = 2'b11
   } state_t;

   state_t                 state_r;
   logic [HW-1:0]          holdcnt_r;
   logic [DIV_WIDTH-1:0]   divcnt_r;
   logic [DIV_WIDTH-1:0]   div_r;
   logic [STEP_WIDTH-1:0]  steps_r;
   logic [COUNT_WIDTH-1:0] count_r;
   logic                   cpuen_r;
   logic                   cpurstn_r;
   logic                   halted_r;
   logic                   done_r;
   logic [DIV_WIDTH-1:0]   divnext_s;

   // Next divider count; the enable is registered one cycle ahead from this value.
   always_comb begin
      divnext_s = {DIV_WIDTH{1'b0}};
      if (divcnt_r != div_r) begin
         divnext_s = divcnt_r + DIV_WIDTH'(1);
      end else begin
         divnext_s = {DIV_WIDTH{1'b0}};
      end
   end

   // Sequencer state machine with registered outputs.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_r   <= S_HOLD;
         holdcnt_r <= {HW{1'b0}};
         divcnt_r  <= {DIV_WIDTH{1'b0}};
         div_r     <= {DIV_WIDTH{1'b0}};
         steps_r   <= {STEP_WIDTH{1'b0}};
         count_r   <= {COUNT_WIDTH{1'b0}};
         cpuen_r   <= 1'b0;
         cpurstn_r <= 1'b0;
         halted_r  <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (cpuen_r) begin
            count_r <= count_r + COUNT_WIDTH'(1);
         end
         case (state_r)
            S_HOLD: begin
               cpuen_r   <= 1'b0;
               holdcnt_r <= holdcnt_r + HW'(1);
               if (holdcnt_r == HW'(RESET_HOLD - 1)) begin
                  state_r   <= S_IDLE;
                  cpurstn_r <= 1'b1;
                  halted_r  <= 1'b1;
               end
            end
            S_IDLE: begin
               cpuen_r <= 1'b0;
               if (Start) begin
                  case (Mode)
                     2'b01: begin
                        div_r    <= Divide;
                        divcnt_r <= {DIV_WIDTH{1'b0}};
                        cpuen_r  <= (Divide == {DIV_WIDTH{1'b0}});
                        halted_r <= 1'b0;
                        state_r  <= S_RUN;
                     end
                     2'b10: begin
                        if (StepCount != {STEP_WIDTH{1'b0}}) begin
                           div_r    <= Divide;
                           steps_r  <= StepCount;
                           divcnt_r <= {DIV_WIDTH{1'b0}};
                           cpuen_r  <= (Divide == {DIV_WIDTH{1'b0}});
                           halted_r <= 1'b0;
                           state_r  <= S_STEP;
                        end else begin
                           done_r <= 1'b1;
                        end
                     end
                     default: begin
                        state_r <= S_IDLE;
                     end
                  endcase
               end
            end
            S_RUN: begin
               if (Halt) begin
                  state_r  <= S_IDLE;
                  halted_r <= 1'b1;
                  done_r   <= 1'b1;
                  cpuen_r  <= 1'b0;
                  divcnt_r <= {DIV_WIDTH{1'b0}};
               end else begin
                  divcnt_r <= divnext_s;
                  cpuen_r  <= (divnext_s == div_r);
               end
            end
            S_STEP: begin
               if (cpuen_r) begin
                  steps_r <= steps_r - STEP_WIDTH'(1);
               end
               // Halt and last-step completion share one exit, so Done stays a single pulse.
               if (Halt || (cpuen_r && (steps_r == STEP_WIDTH'(1)))) begin
                  state_r  <= S_IDLE;
                  halted_r <= 1'b1;
                  done_r   <= 1'b1;
                  cpuen_r  <= 1'b0;
                  divcnt_r <= {DIV_WIDTH{1'b0}};
               end else begin
                  divcnt_r <= divnext_s;
                  cpuen_r  <= (divnext_s == div_r);
               end
            end
            default: begin
               state_r <= S_HOLD;
               cpuen_r <= 1'b0;
            end
         endcase
      end
   end

   assign CpuEnable  = cpuen_r;
   assign CpuReset_n = cpurstn_r;
   assign CycleCount = count_r;
   assign Halted     = halted_r;
   assign Done       = done_r;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: vector table plus scripted
// sequences, expectations queued at drive time and checked after each edge.
module tb_cpu_clock_controller;

   typedef struct {
      logic        rst;
      logic [1:0]  mode;
      logic        start;
      logic        halt;
      logic [7:0]  div;
      logic [15:0] sc;
      logic        en;
      logic        rstn;
      logic        hal;
      logic        done;
      logic [31:0] cnt;
   } vec_t;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [1:0]  Mode;
   logic        Start;
   logic        Halt;
   logic [7:0]  Divide;
   logic [15:0] StepCount;
   logic        CpuEnable, CpuReset_n, Halted, Done;
   logic [31:0] CycleCount;
   logic        CpuEnable4, CpuReset_n4, Halted4, Done4;
   logic [3:0]  CycleCount4;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t exp_q[$];
   vec_t tbl[$];

   always #5 Clock = ~Clock;

   cpu_clock_controller u_dut (
      .Clock(Clock), .Reset(Reset), .Mode(Mode), .Start(Start), .Halt(Halt),
      .Divide(Divide), .StepCount(StepCount), .CpuEnable(CpuEnable),
      .CpuReset_n(CpuReset_n), .CycleCount(CycleCount), .Halted(Halted), .Done(Done)
   );

   cpu_clock_controller #(.COUNT_WIDTH(4)) u_dut4 (
      .Clock(Clock), .Reset(Reset), .Mode(Mode), .Start(Start), .Halt(Halt),
      .Divide(Divide), .StepCount(StepCount), .CpuEnable(CpuEnable4),
      .CpuReset_n(CpuReset_n4), .CycleCount(CycleCount4), .Halted(Halted4), .Done(Done4)
   );

   function automatic vec_t mk(input int rst, input int mode, input int start, input int halt,
                               input int div, input int sc, input int en, input int rstn,
                               input int hal, input int done, input int cnt);
      vec_t v;
      v.rst = 1'(rst); v.mode = 2'(mode); v.start = 1'(start); v.halt = 1'(halt);
      v.div = 8'(div); v.sc = 16'(sc);
      v.en = 1'(en); v.rstn = 1'(rstn); v.hal = 1'(hal); v.done = 1'(done);
      v.cnt = 32'(cnt);
      return v;
   endfunction

   task automatic apply(input string name, input vec_t v);
      vec_t e;
      Reset = v.rst; Mode = v.mode; Start = v.start; Halt = v.halt;
      Divide = v.div; StepCount = v.sc;
      exp_q.push_back(v);
      @(posedge Clock);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (CpuEnable !== e.en || CpuReset_n !== e.rstn || Halted !== e.hal ||
          Done !== e.done || CycleCount !== e.cnt || CycleCount4 !== e.cnt[3:0]) begin
         n_fail++;
         $display("FAIL %s: got en=%b rstn=%b halted=%b done=%b cnt=%0d cnt4=%0d, want en=%b rstn=%b halted=%b done=%b cnt=%0d cnt4=%0d",
                  name, CpuEnable, CpuReset_n, Halted, Done, CycleCount, CycleCount4,
                  e.en, e.rstn, e.hal, e.done, e.cnt, e.cnt[3:0]);
      end
   endtask

   initial begin
      Reset = 1'b0; Mode = 2'b00; Start = 1'b0; Halt = 1'b0;
      Divide = 8'd0; StepCount = 16'd0;

      // Reset, hold sequence, ignored requests in IDLE, then a 5-step run.
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,1,1,0,0));
      tbl.push_back(mk(1,0,0,1,0,0, 0,1,1,0,0));
      tbl.push_back(mk(1,0,1,0,3,5, 0,1,1,0,0));
      tbl.push_back(mk(1,3,1,0,3,5, 0,1,1,0,0));
      tbl.push_back(mk(1,2,1,0,0,5, 1,1,0,0,0));
      for (int i = 1; i <= 4; i++) tbl.push_back(mk(1,0,0,0,7,9, 1,1,0,0,i));
      tbl.push_back(mk(1,0,0,0,7,9, 0,1,1,1,5));
      tbl.push_back(mk(1,0,0,0,7,9, 0,1,1,0,5));
      for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl[%0d]", i), tbl[i]);

      // RUN with Divide=2; Divide driven to 0 afterwards must not matter.
      apply("run_start", mk(1,1,1,0,2,0, 0,1,0,0,5));
      for (int k = 1; k <= 30; k++)
         apply($sformatf("run_div2_%0d", k), mk(1,0,0,0,0,0, int'(k % 3 == 2),1,0,0, 5 + k / 3));
      apply("run_halt", mk(1,0,0,1,0,0, 0,1,1,1,15));
      apply("run_idle", mk(1,0,0,0,0,0, 0,1,1,0,15));

      // Halt during a tick: that tick counts, then a zero-step request.
      apply("ht_start", mk(1,1,1,0,0,0, 1,1,0,0,15));
      apply("ht_tick",  mk(1,0,0,0,0,0, 1,1,0,0,16));
      apply("ht_halt",  mk(1,0,0,1,0,0, 0,1,1,1,17));
      apply("ht_idle",  mk(1,0,0,0,0,0, 0,1,1,0,17));
      apply("step0",    mk(1,2,1,0,0,0, 0,1,1,1,17));
      apply("step0_after", mk(1,0,0,0,0,0, 0,1,1,0,17));

      // Reset while stepping with 3 steps remaining; hold sequence repeats.
      apply("rs_start", mk(1,2,1,0,1,5, 0,1,0,0,17));
      apply("rs_1", mk(1,0,0,0,0,0, 1,1,0,0,17));
      apply("rs_2", mk(1,0,0,0,0,0, 0,1,0,0,18));
      apply("rs_3", mk(1,0,0,0,0,0, 1,1,0,0,18));
      apply("rs_4", mk(1,0,0,0,0,0, 0,1,0,0,19));
      apply("rs_reset", mk(0,0,0,0,0,0, 0,0,0,0,0));
      for (int i = 0; i < 3; i++) apply($sformatf("rs_hold%0d", i), mk(1,0,0,0,0,0, 0,0,0,0,0));
      apply("rs_release", mk(1,0,0,0,0,0, 0,1,1,0,0));

      // Count wrap on the 4-bit instance; a Start during RUN is ignored.
      apply("wr_start", mk(1,1,1,0,0,0, 1,1,0,0,0));
      for (int k = 1; k <= 17; k++)
         apply($sformatf("wrap_%0d", k), mk(1,(k == 8) ? 2 : 0,int'(k == 8),0,5,3, 1,1,0,0,k));
      apply("wr_halt", mk(1,0,0,1,0,0, 0,1,1,1,18));
      apply("wr_idle", mk(1,0,0,0,0,0, 0,1,1,0,18));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
Synthesizable clock-enable and reset sequencer for the 16-bit CPU. It replaces free-running bench clock toggling with a controlled core: it holds the CPU in reset after system reset, then either runs the CPU continuously at a programmable divided rate or single-steps it for N ticks. It also counts every CPU tick. It sits between the board/bench Clock and the CPU's enable and reset inputs.

Parameters:
DIV_WIDTH, 8, width of the divide ratio; a CPU tick occurs every Divide+1 Clock cycles
STEP_WIDTH, 16, width of the step-count request and the internal remaining-steps counter
COUNT_WIDTH, 32, width of the CycleCount tick counter
RESET_HOLD, 4, number of Clock cycles (≥1) that CpuReset_n is held low after Reset is released

Ports:
Clock  input  1  system clock; all logic on the rising edge
Reset  input  1  synchronous, active-low reset
Mode  input  2  sampled with Start: 01 = RUN, 10 = STEP; 00 and 11 are ignored
Start  input  1  single-cycle request; honoured only in IDLE
Halt  input  1  stop request; honoured in RUN and STEP
Divide  input  DIV_WIDTH  divide ratio minus one; latched on an accepted Start
StepCount  input  STEP_WIDTH  number of ticks for STEP; latched on an accepted Start
CpuEnable  output  1  one-cycle tick strobe to the CPU
CpuReset_n  output  1  active-low reset to the CPU
CycleCount  output  COUNT_WIDTH  total ticks issued since reset
Halted  output  1  high while in IDLE
Done  output  1  one-cycle pulse on every return to IDLE from RUN or STEP

Behaviour:
- Reset is synchronous, active-low. One clock; no other clock domains.
- On any edge where Reset=0:
  - state = HOLD
  - CpuReset_n = 0, CpuEnable = 0, Halted = 0, Done = 0
  - CycleCount, divcnt, holdcnt, StepsLeft, DivLatched all = 0
- HOLD:
  - holdcnt increments on each edge with Reset=1.
  - On the RESET_HOLD-th such edge: CpuReset_n becomes 1, state becomes IDLE, Halted becomes 1.
- IDLE:
  - CpuEnable = 0.
  - Start=1 with Mode=01: latch Divide, clear divcnt, go to RUN.
  - Start=1 with Mode=10 and StepCount≠0: latch Divide and StepCount, clear divcnt, go to STEP.
  - Start=1 with Mode=10 and StepCount=0: stay in IDLE and pulse Done for one cycle.
  - Start=1 with Mode 00 or 11: ignored.
  - Halted falls on the same edge that leaves IDLE.
- Divider (RUN and STEP):
  - divcnt counts 0..DivLatched and wraps to 0.
  - CpuEnable is decoded from registers only: (state is RUN or STEP) AND divcnt==DivLatched. There is no combinational path from any input.
  - First tick is DivLatched+1 cycles after the Start edge. With Divide=0, CpuEnable is high every cycle.
- CycleCount increments on every edge where CpuEnable=1 and wraps modulo 2^COUNT_WIDTH.
- STEP:
  - StepsLeft decrements on every edge where CpuEnable=1.
  - On the edge where StepsLeft==1 and CpuEnable=1: go to IDLE, set Halted=1, pulse Done for one cycle.
  - Exactly StepCount ticks are issued.
- Halt:
  - Halt=1 in RUN or STEP: go to IDLE on that edge, set Halted=1, pulse Done. No further CpuEnable.
  - If CpuEnable is already high in the Halt cycle, that tick still counts.
  - Halt has priority over step completion; Done is still a single pulse.
- Start while in RUN or STEP: ignored. Halt while in IDLE or HOLD: ignored.
- Reset mid-run: on the same edge, go to HOLD. CpuReset_n drops to 0 and all state is cleared, including CycleCount.
- Divide and StepCount changes after an accepted Start have no effect until the next Start.

Test Plan:
- Reset low 3 cycles then high, RESET_HOLD=4 -> CpuReset_n rises on the 4th edge with Reset high; Halted=1; CycleCount=0; CpuEnable never high.
- Start, Mode=01, Divide=2 -> CpuEnable high one cycle in every 3, first tick 3 cycles after Start; after 30 cycles CycleCount=10.
- Start, Mode=10, StepCount=5, Divide=0 -> exactly 5 consecutive CpuEnable cycles; Done pulses on the 5th; Halted=1; CycleCount=5.
- RUN with Divide=0, Halt asserted in a tick cycle -> that tick is counted, no further ticks, Done pulses once; then Start with Mode=10, StepCount=0 -> Done pulses and CycleCount is unchanged.
- Reset low during STEP with 3 steps remaining -> next cycle CpuReset_n=0, CycleCount=0, CpuEnable=0; after release the HOLD sequence repeats.
- COUNT_WIDTH=4, RUN with Divide=0 for 17 cycles -> CycleCount wraps from 15 to 0 and reads 1; Start pulsed during RUN is ignored.
